id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 32, operand/result datapath width.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 stall_i  input  1  pipeline freeze (data-cache miss or hazard hold).
REQ-005 flush_i  input  1  squash the instruction entering EX (taken branch).
REQ-006 valid_i  input  1  ID slot holds a real instruction.
REQ-007 rs1_data_i, rs2_data_i, imm_i  input  DATA_W each  register-file reads and sign-extended immediate.
REQ-008 rs1_addr_i, rs2_addr_i, rd_addr_i  input  5 each  register indices.
REQ-009 alu_ctrl_i  input  3  ALU op code (ADD 001, SUB 010, MUL 011, AND 100, XOR 101, SLL 110, SRA 111).
REQ-010 alusrc_i, regwrite_i, memread_i, memwrite_i, memtoreg_i  input  1 each  decoded controls.
REQ-011 exmem_regwrite_i  input  1; exmem_rd_i  input  5; exmem_data_i  input  DATA_W  EX/MEM forwarding source.
REQ-012 memwb_regwrite_i  input  1; memwb_rd_i  input  5; memwb_data_i  input  DATA_W  MEM/WB forwarding source.
REQ-013 data1_o, data2_o  output  DATA_W  ALU operands.
REQ-014 alu_ctrl_o  output  3  registered ALU op code.
REQ-015 store_data_o  output  DATA_W  forwarded rs2 value for stores.
REQ-016 rd_addr_o  output  5; regwrite_o, memread_o, memwrite_o, memtoreg_o  output  1 each  registered controls.
REQ-017 valid_o  output  1  EX slot holds a real instruction.
REQ-018 load_use_o  output  1  ID instruction depends on a load in EX.

Function
REQ-019 Update priority per edge: stall_i hold > bubble (flush_i or pending flush) > load from ID inputs.
REQ-020 stall_i=1: every registered field SHALL keep its value.
REQ-021 flush_i=1 with stall_i=1: a pending-flush flag SHALL be set; the next edge with stall_i=0 SHALL load a bubble and clear the flag.
REQ-022 Bubble: valid, regwrite, memread, memwrite, memtoreg SHALL be 0 and rd_addr SHALL be 0; datapath fields are don't-care.
REQ-023 Load: all ID inputs captured; valid_o SHALL equal valid_i; controls SHALL be forced 0 when valid_i=0.
REQ-024 Latency: ID inputs appear on outputs one clock after capture.
REQ-025 Forwarding (combinational on registered rs1/rs2): EX/MEM source if exmem_regwrite_i and exmem_rd_i==rs and rs!=0; else MEM/WB source if memwb_regwrite_i and memwb_rd_i==rs and rs!=0; else registered register-file value.
REQ-026 EX/MEM SHALL win when both sources match the same rs.
REQ-027 data1_o SHALL be forwarded rs1; store_data_o SHALL be forwarded rs2; data2_o SHALL be imm when registered alusrc=1, else forwarded rs2.
REQ-028 Register x0 SHALL never be forwarded; registered value passes through.
REQ-029 load_use_o = valid_o & memread_o & (rd_addr_o!=0) & (rd_addr_o==rs1_addr_i | rd_addr_o==rs2_addr_i) & valid_i; combinational.
REQ-030 No arithmetic is performed here; all widths pass unmodified.

Reset
REQ-031 rst_i=1 SHALL immediately clear all registered fields, pending-flush flag, valid_o, and controls to 0; alu_ctrl_o resets to 000.
REQ-032 Reset asserted mid-stall or with a pending flush SHALL discard both; first post-reset edge performs a normal load.

Structure
REQ-033 ALU op code constants and DATA_W default SHALL live in the shared CPU package used by the ALU.
REQ-034 Forwarding selection SHALL be one sub-module, fwd_mux, instantiated twice (rs1, rs2).

Verification
REQ-035 Load ADD x3=x1+x2, rs1=5, rs2=7, no forwarding -> next cycle data1_o=5, data2_o=7, alu_ctrl_o=001, valid_o=1.
REQ-036 exmem writes x1=100, memwb writes x1=50, current rs1=x1 -> data1_o=100; exmem_rd=0 with rs1=x0 -> registered value.
REQ-037 stall_i high 3 cycles with new ID inputs -> outputs unchanged; flush_i pulse in cycle 2 -> bubble (valid_o=0, regwrite_o=0) on first unstalled edge.
REQ-038 EX holds lw x4, ID reads rs2=x4 -> load_use_o=1; rd=x0 or valid_i=0 -> load_use_o=0.
REQ-039 alusrc=1, imm=-4 (0xFFFFFFFC), rs2 forwarded=9 -> data2_o=0xFFFFFFFC, store_data_o=9.
REQ-040 rst_i pulsed asynchronously mid-stall -> all outputs 0 without clock edge; next edge loads ID inputs.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared CPU package: datapath width default, ALU op codes and the ID/EX control bundle.
package id_ex_stage_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        ALU_NOP = 3'b000,
        ALU_ADD = 3'b001,
        ALU_SUB = 3'b010,
        ALU_MUL = 3'b011,
        ALU_AND = 3'b100,
        ALU_XOR = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        alu_op_e               alu_ctrl;
        logic                  alusrc;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  memtoreg;
    } ex_ctrl_t;

    // All-zero bundle: not valid, writes nothing, rd = x0, rs = x0 so nothing forwards.
    localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one source register; EX/MEM beats MEM/WB, x0 never forwards.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic [4:0]        rs_addr_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic              exmem_regwrite_i,
    input  logic [4:0]        exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_regwrite_i,
    input  logic [4:0]        memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] data_o
);

    logic rs_nonzero;
    logic hit_exmem;
    logic hit_memwb;

    assign rs_nonzero = (rs_addr_i != 5'd0);
    assign hit_exmem  = exmem_regwrite_i && (exmem_rd_i == rs_addr_i) && rs_nonzero;
    assign hit_memwb  = memwb_regwrite_i && (memwb_rd_i == rs_addr_i) && rs_nonzero;

    assign data_o = hit_exmem ? exmem_data_i :
                    hit_memwb ? memwb_data_i : rs_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall hold, (deferred) flush bubbles, operand forwarding
// and load-use detection against the instruction currently in ID.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        rs1_addr_i,
    input  logic [4:0]        rs2_addr_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [2:0]        alu_ctrl_i,
    input  logic              alusrc_i,
    input  logic              regwrite_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              memtoreg_i,
    input  logic              exmem_regwrite_i,
    input  logic [4:0]        exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_regwrite_i,
    input  logic [4:0]        memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [2:0]        alu_ctrl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [4:0]        rd_addr_o,
    output logic              regwrite_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic              memtoreg_o,
    output logic              valid_o,
    output logic              load_use_o
);

    ex_ctrl_t          ctrl_q, ctrl_d, id_ctrl;
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              flush_pend_q, flush_pend_d;
    logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

    always_comb begin
        id_ctrl          = EX_CTRL_BUBBLE;
        id_ctrl.valid    = valid_i;
        id_ctrl.rs1      = rs1_addr_i;
        id_ctrl.rs2      = rs2_addr_i;
        id_ctrl.rd       = rd_addr_i;
        id_ctrl.alu_ctrl = alu_op_e'(alu_ctrl_i);
        id_ctrl.alusrc   = alusrc_i;
        // An empty ID slot must not write registers or memory downstream.
        id_ctrl.regwrite = regwrite_i & valid_i;
        id_ctrl.memread  = memread_i  & valid_i;
        id_ctrl.memwrite = memwrite_i & valid_i;
        id_ctrl.memtoreg = memtoreg_i & valid_i;
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        flush_pend_d = 1'b0;
        if (stall_i) begin
            // A branch flush seen while frozen is remembered for the first free edge.
            flush_pend_d = flush_pend_q | flush_i;
        end else if (flush_i || flush_pend_q) begin
            ctrl_d     = EX_CTRL_BUBBLE;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
        end else begin
            ctrl_d     = id_ctrl;
            rs1_data_d = rs1_data_i;
            rs2_data_d = rs2_data_i;
            imm_d      = imm_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q       <= EX_CTRL_BUBBLE;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs1 (
        .rs_addr_i        (ctrl_q.rs1),
        .rs_data_i        (rs1_data_q),
        .exmem_regwrite_i (exmem_regwrite_i),
        .exmem_rd_i       (exmem_rd_i),
        .exmem_data_i     (exmem_data_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_rd_i       (memwb_rd_i),
        .memwb_data_i     (memwb_data_i),
        .data_o           (fwd_rs1)
    );

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs2 (
        .rs_addr_i        (ctrl_q.rs2),
        .rs_data_i        (rs2_data_q),
        .exmem_regwrite_i (exmem_regwrite_i),
        .exmem_rd_i       (exmem_rd_i),
        .exmem_data_i     (exmem_data_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_rd_i       (memwb_rd_i),
        .memwb_data_i     (memwb_data_i),
        .data_o           (fwd_rs2)
    );

    assign data1_o      = fwd_rs1;
    assign data2_o      = ctrl_q.alusrc ? imm_q : fwd_rs2;
    assign store_data_o = fwd_rs2;
    assign alu_ctrl_o   = ctrl_q.alu_ctrl;
    assign rd_addr_o    = ctrl_q.rd;
    assign regwrite_o   = ctrl_q.regwrite;
    assign memread_o    = ctrl_q.memread;
    assign memwrite_o   = ctrl_q.memwrite;
    assign memtoreg_o   = ctrl_q.memtoreg;
    assign valid_o      = ctrl_q.valid;

    assign load_use_o = ctrl_q.valid & ctrl_q.memread & (ctrl_q.rd != 5'd0) &
                        ((ctrl_q.rd == rs1_addr_i) | (ctrl_q.rd == rs2_addr_i)) & valid_i;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a table of single-edge vectors plus hand sequences for
// stall/flush, load-use and asynchronous reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  alu_ctrl;
    logic        alusrc, regwrite, memread, memwrite, memtoreg;
    logic        ex_rw, wb_rw;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] ex_data, wb_data;
    logic [31:0] data1, data2, store_data;
    logic [2:0]  alu_ctrl_out;
    logic [4:0]  rd_out;
    logic        rw_out, mr_out, mw_out, mtr_out, v_out, lu_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        valid;
        logic [31:0] rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  alu;
        logic        alusrc, rw, mr, mw, mtr;
        logic        ex_rw;
        logic [4:0]  ex_rd;
        logic [31:0] ex_data;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] e_d1, e_d2, e_st;
        logic [2:0]  e_alu;
        logic [4:0]  e_rd;
        logic        e_v, e_rw, e_mr, e_mw, e_mtr, e_lu;
    } vec_t;

    vec_t vt[11];

    id_ex_stage #(.DATA_W(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .stall_i          (stall),
        .flush_i          (flush),
        .valid_i          (valid),
        .rs1_data_i       (rs1_data),
        .rs2_data_i       (rs2_data),
        .imm_i            (imm),
        .rs1_addr_i       (rs1_addr),
        .rs2_addr_i       (rs2_addr),
        .rd_addr_i        (rd_addr),
        .alu_ctrl_i       (alu_ctrl),
        .alusrc_i         (alusrc),
        .regwrite_i       (regwrite),
        .memread_i        (memread),
        .memwrite_i       (memwrite),
        .memtoreg_i       (memtoreg),
        .exmem_regwrite_i (ex_rw),
        .exmem_rd_i       (ex_rd),
        .exmem_data_i     (ex_data),
        .memwb_regwrite_i (wb_rw),
        .memwb_rd_i       (wb_rd),
        .memwb_data_i     (wb_data),
        .data1_o          (data1),
        .data2_o          (data2),
        .alu_ctrl_o       (alu_ctrl_out),
        .store_data_o     (store_data),
        .rd_addr_o        (rd_out),
        .regwrite_o       (rw_out),
        .memread_o        (mr_out),
        .memwrite_o       (mw_out),
        .memtoreg_o       (mtr_out),
        .valid_o          (v_out),
        .load_use_o       (lu_out)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        valid    = v.valid;
        rs1_data = v.rs1_data;
        rs2_data = v.rs2_data;
        imm      = v.imm;
        rs1_addr = v.rs1;
        rs2_addr = v.rs2;
        rd_addr  = v.rd;
        alu_ctrl = v.alu;
        alusrc   = v.alusrc;
        regwrite = v.rw;
        memread  = v.mr;
        memwrite = v.mw;
        memtoreg = v.mtr;
        ex_rw    = v.ex_rw;
        ex_rd    = v.ex_rd;
        ex_data  = v.ex_data;
        wb_rw    = v.wb_rw;
        wb_rd    = v.wb_rd;
        wb_data  = v.wb_data;
    endtask

    task automatic fwd_off();
        ex_rw = 0; ex_rd = 0; ex_data = 0;
        wb_rw = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d_data1", i), data1, v.e_d1);
        chk($sformatf("v%0d_data2", i), data2, v.e_d2);
        chk($sformatf("v%0d_store", i), store_data, v.e_st);
        chk($sformatf("v%0d_alu", i), {29'd0, alu_ctrl_out}, {29'd0, v.e_alu});
        chk($sformatf("v%0d_rd", i), {27'd0, rd_out}, {27'd0, v.e_rd});
        chk($sformatf("v%0d_ctrl", i), {26'd0, v_out, rw_out, mr_out, mw_out, mtr_out, lu_out},
            {26'd0, v.e_v, v.e_rw, v.e_mr, v.e_mw, v.e_mtr, v.e_lu});
    endtask

    initial begin
        //      v  rs1d          rs2d          imm           rs1 rs2 rd  alu     as rw mr mw mt  exrw exrd exdata   wbrw wbrd wbdata  e_d1          e_d2          e_st          e_alu   erd v  rw mr mw mt lu
        vt[0]  = '{1, 5,           7,            0,            1,  2,  3,  3'b001, 0, 1, 0, 0, 0,  0,   0,   0,       0,   0,   0,      5,            7,            7,            3'b001, 3,  1, 1, 0, 0, 0, 0};
        vt[1]  = '{1, 11,          22,           0,            1,  2,  6,  3'b010, 0, 1, 0, 0, 0,  1,   1,   100,     1,   1,   50,     100,          22,           22,           3'b010, 6,  1, 1, 0, 0, 0, 0};
        vt[2]  = '{1, 1,           2,            0,            1,  2,  7,  3'b011, 0, 1, 0, 0, 0,  1,   9,   77,      1,   2,   50,     1,            50,           50,           3'b011, 7,  1, 1, 0, 0, 0, 0};
        vt[3]  = '{1, 32'h1234,    32'h5678,     0,            0,  0,  8,  3'b100, 0, 1, 0, 0, 0,  1,   0,   99,      1,   0,   88,     32'h1234,     32'h5678,     32'h5678,     3'b100, 8,  1, 1, 0, 0, 0, 0};
        vt[4]  = '{1, 3,           6,            0,            5,  6,  9,  3'b101, 0, 1, 0, 0, 0,  0,   5,   44,      1,   5,   55,     55,           6,            6,            3'b101, 9,  1, 1, 0, 0, 0, 0};
        vt[5]  = '{1, 2,           1,            32'hFFFFFFFC, 8,  7,  0,  3'b001, 1, 0, 0, 1, 0,  1,   7,   9,       0,   0,   0,      2,            32'hFFFFFFFC, 9,            3'b001, 0,  1, 0, 0, 1, 0, 0};
        vt[6]  = '{0, 3,           0,            0,            3,  0,  4,  3'b011, 0, 1, 1, 1, 1,  0,   0,   0,       0,   0,   0,      3,            0,            0,            3'b011, 4,  0, 0, 0, 0, 0, 0};
        vt[7]  = '{1, 32'h40,      0,            8,            4,  0,  4,  3'b001, 1, 1, 1, 0, 1,  0,   0,   0,       0,   0,   0,      32'h40,       8,            0,            3'b001, 4,  1, 1, 1, 0, 1, 1};
        vt[8]  = '{1, 0,           0,            0,            0,  0,  0,  3'b001, 1, 1, 1, 0, 1,  0,   0,   0,       0,   0,   0,      0,            0,            0,            3'b001, 0,  1, 1, 1, 0, 1, 0};
        vt[9]  = '{1, 32'hFFFFFFFF,32'h80000000, 0,            31, 30, 31, 3'b110, 0, 1, 0, 0, 0,  1,   31,  32'hDEAD, 1,  30,  1,      32'hDEAD,     1,            1,            3'b110, 31, 1, 1, 0, 0, 0, 0};
        vt[10] = '{1, 32'h80000000,3,            0,            2,  3,  2,  3'b111, 0, 1, 0, 0, 0,  1,   3,   32'hAA,  1,   3,   32'hBB, 32'h80000000, 32'hAA,       32'hAA,       3'b111, 2,  1, 1, 0, 0, 0, 0};

        // Reset: busy ID inputs, no clock edge yet, everything must read zero.
        rst = 1; stall = 0; flush = 0;
        apply_vec(vt[0]);
        fwd_off();
        #2;
        chk("rst_valid", {31'd0, v_out}, 32'd0);
        chk("rst_ctrls", {28'd0, rw_out, mr_out, mw_out, mtr_out}, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        chk("rst_alu", {29'd0, alu_ctrl_out}, 32'd0);
        chk("rst_data1", data1, 32'd0);
        chk("rst_load_use", {31'd0, lu_out}, 32'd0);
        #1 rst = 0;

        for (int i = 0; i < 11; i++) begin
            apply_vec(vt[i]);
            tick();
            check_vec(i, vt[i]);
        end

        // Load-use against the live ID slot.
        apply_vec(vt[7]);
        tick();
        rs1_addr = 1; rs2_addr = 4; valid = 1; #1;
        chk("lu_rs2_hit", {31'd0, lu_out}, 32'd1);
        rs2_addr = 5; #1;
        chk("lu_no_hit", {31'd0, lu_out}, 32'd0);
        rs2_addr = 4; valid = 0; #1;
        chk("lu_id_invalid", {31'd0, lu_out}, 32'd0);
        apply_vec(vt[8]);
        tick();
        rs1_addr = 0; rs2_addr = 0; valid = 1; #1;
        chk("lu_rd_x0", {31'd0, lu_out}, 32'd0);

        // Flush without stall: bubble on the same edge.
        apply_vec(vt[0]);
        flush = 1;
        tick();
        flush = 0;
        chk("flush_valid", {31'd0, v_out}, 32'd0);
        chk("flush_rd_rw", {26'd0, rd_out, rw_out}, 32'd0);

        // Three stalled edges with new ID inputs; flush pulsed in the second one.
        apply_vec(vt[0]);
        tick();
        apply_vec(vt[1]);
        fwd_off();
        stall = 1;
        for (int c = 0; c < 3; c++) exp_q.push_back({24'd0, 3'd3, 4'd0, 1'b1});
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            tick();
            chk($sformatf("stall%0d_rd_valid", c), {24'd0, rd_out, 4'd0, v_out}, exp_q.pop_front());
            chk($sformatf("stall%0d_data1", c), data1, 32'd5);
        end
        flush = 0; stall = 0;
        tick();
        chk("pend_bubble_valid", {31'd0, v_out}, 32'd0);
        chk("pend_bubble_rw_rd", {26'd0, rd_out, rw_out}, 32'd0);
        tick();
        chk("post_bubble_load", {23'd0, rd_out, data1[3:0]}, {23'd0, 5'd6, 4'd11});
        chk("post_bubble_valid", {31'd0, v_out}, 32'd1);

        // Asynchronous reset mid-stall with a pending flush.
        apply_vec(vt[0]);
        tick();
        apply_vec(vt[1]);
        fwd_off();
        stall = 1; flush = 1;
        tick();
        #2 rst = 1;
        #1;
        chk("arst_valid_rw", {30'd0, v_out, rw_out}, 32'd0);
        chk("arst_rd_alu", {24'd0, rd_out, alu_ctrl_out}, 32'd0);
        chk("arst_data1", data1, 32'd0);
        rst = 0; stall = 0; flush = 0;
        apply_vec(vt[0]);
        tick();
        chk("arst_next_load", {27'd0, rd_out}, 32'd3);
        chk("arst_next_valid", {31'd0, v_out}, 32'd1);
        chk("arst_next_data1", data1, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
